// File: rtl/mode_button_ctrl.sv
// Front-end controller for the clock/date/alarm/stopwatch display.
// Classifies two debounced buttons into short/long press events, owns the
// display-mode FSM, and freezes the time/date chain while any block is setting.

// Per-button short/long classifier, advanced only on tick strobes.
module mode_button_ctrl_btn #(
    parameter int LONG_TICKS = 100,
    parameter int CW         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic short_det,
    output logic short_evt,
    output logic long_evt
);

    localparam logic [CW-1:0] LT_C     = CW'(LONG_TICKS);
    localparam logic [CW-1:0] LT_M1    = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          armed;
    logic          prev;
    logic          short_hit;
    logic          long_hit;

    // Next hold count and event detection for the current button sample.
    always_comb begin
        cnt_next  = cnt;
        short_hit = 1'b0;
        long_hit  = 1'b0;
        if (btn) begin
            // Saturating at LONG_TICKS keeps the long event to one per press.
            if (armed && (cnt < LT_C)) begin
                cnt_next = cnt + 1'b1;
                if (cnt == LT_M1) begin
                    long_hit = 1'b1;
                end
            end
        end else begin
            cnt_next = CNT_ZERO;
            // A count of LONG_TICKS means the long event already fired.
            if (armed && prev && (cnt != CNT_ZERO) && (cnt < LT_C)) begin
                short_hit = 1'b1;
            end
        end
    end

    // The mode FSM needs the short detection on the detecting tick itself.
    assign short_det = tick & short_hit;

    // Tick-paced state; events are held for a whole tick period so slower
    // derived-clock consumers are guaranteed to sample them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= CNT_ZERO;
            armed     <= 1'b0;
            prev      <= 1'b0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else if (tick) begin
            cnt       <= cnt_next;
            prev      <= btn;
            // A button held through reset stays disarmed until first released.
            armed     <= armed | ~btn;
            short_evt <= short_hit;
            long_evt  <= long_hit;
        end
    end

endmodule

module mode_button_ctrl #(
    parameter int LONG_TICKS = 100,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       b0,
    input  logic       b1,
    input  logic       setting_busy,
    output logic [1:0] mode,
    output logic       b0short,
    output logic       b0long,
    output logic       b1short,
    output logic       b1long,
    output logic       stop
);

    typedef enum logic [1:0] {
        MODE_TIME      = 2'b00,
        MODE_DATE      = 2'b01,
        MODE_ALARM     = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_t;

    mode_t state_q;
    mode_t state_d;
    logic  b0_short_det;
    logic  b1_short_det;

    mode_button_ctrl_btn #(
        .LONG_TICKS (LONG_TICKS),
        .CW         (CW)
    ) u_btn0 (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn       (b0),
        .short_det (b0_short_det),
        .short_evt (b0short),
        .long_evt  (b0long)
    );

    mode_button_ctrl_btn #(
        .LONG_TICKS (LONG_TICKS),
        .CW         (CW)
    ) u_btn1 (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .btn       (b1),
        .short_det (b1_short_det),
        .short_evt (b1short),
        .long_evt  (b1long)
    );

    // Mode state register; updates alongside the b0short event register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MODE_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Advance on a b0 short press unless a mode block is busy setting.
    always_comb begin
        state_d = state_q;
        if (b0_short_det && !setting_busy) begin
            case (state_q)
                MODE_TIME:      state_d = MODE_DATE;
                MODE_DATE:      state_d = MODE_ALARM;
                MODE_ALARM:     state_d = MODE_STOPWATCH;
                MODE_STOPWATCH: state_d = MODE_TIME;
                default:        state_d = MODE_TIME;
            endcase
        end
    end

    assign mode = state_q;

    // Registered freeze of the time/date chain, one cycle behind busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop <= 1'b0;
        end else begin
            stop <= setting_busy;
        end
    end

    // b1 short detection is only consumed by downstream blocks via b1short.
    logic unused_ok;
    assign unused_ok = b1_short_det;

endmodule

// File: doc/mode_button_ctrl.md
# mode_button_ctrl

Front-end controller for the clock/date/alarm/stopwatch display system. Classifies two debounced push-buttons into short/long press events. Owns the display-mode state machine and forwards button events to the mode blocks. Drives the shared `stop` input of the time/date counter chain while any mode block is in its setting state.

## Interface

**Parameters**
- `LONG_TICKS`, default 100: hold duration, in `tick` periods, that makes a press long. 1 s at a 100 Hz tick. Legal range 2..255.
- `CW`, default 8: width of each hold counter. Must satisfy `2^CW > LONG_TICKS`.

**Ports**
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, asynchronous assert, active-low.
- `tick` in 1: one-`clk`-wide sample strobe (100 Hz).
- `b0` in 1: debounced button 0 level, active-high.
- `b1` in 1: debounced button 1 level, active-high.
- `setting_busy` in 1: OR of the `setting` outputs of all mode blocks.
- `mode` out 2: 00 TIME, 01 DATE, 10 ALARM, 11 STOPWATCH.
- `b0short` out 1: short-press event for button 0.
- `b0long` out 1: long-press event for button 0.
- `b1short` out 1: short-press event for button 1.
- `b1long` out 1: long-press event for button 1.
- `stop` out 1: 1 freezes the time/date counter chain.

## Operation

**Reset values.** On reset every output is 0. Internal state resets as follows:
- Hold counters = 0.
- `armed[1:0]` = 0.
- Sampled previous levels = 0.

**Sampling.** All button logic advances only on cycles where `tick`=1. Button levels between ticks are ignored.

**Arming.** A button's classifier is disarmed after reset. It arms on the first tick that samples the button released. While disarmed, the button produces no events. A button held through reset therefore never yields an event.

**Per-button classifier.** Identical for b0 and b1, each fully independent. On each tick:
- Armed and pressed: hold counter increments, saturating at `LONG_TICKS`.
- Counter reaches exactly `LONG_TICKS` on this tick: raise the long event. It fires once per press; saturation prevents a repeat.
- Released after being pressed, with counter in 1..`LONG_TICKS`-1: raise the short event.
- Released, in every case: counter clears to 0.
- A release after a long event produces nothing.

**Event width.** An event output goes high in the `clk` cycle after the detecting tick. It stays high until the `clk` cycle after the next tick, i.e. exactly one tick period. This lets consumers clocked by a slower derived clock sample it.

**Mode FSM.** States cycle TIME → DATE → ALARM → STOPWATCH → TIME.
- Advance occurs on the detecting tick of a b0 short event when `setting_busy`=0 at that tick.
- If `setting_busy`=1 at that tick, the mode is held. The event is still forwarded.
- The new `mode` appears in the same cycle as the `b0short` output rising.

**Forwarding.** All four events are forwarded unconditionally. Each mode block gates them with `mode` itself.

**Stop.** `stop` is registered. `stop` = `setting_busy`, delayed one `clk` cycle.

## Timing

- Event latency: 1 `clk` after the detecting tick. Event width: one tick period.
- Short-press span: tick samples of pressed, counted from the first pressed sample, in the range 1..`LONG_TICKS`-1 at release.
- Long event: on the `LONG_TICKS`-th consecutive pressed sample.
- b0 and b1 events in the same tick are independent and may coincide. The mode FSM uses only b0.
- A b0 short event and a `setting_busy` rise on the same tick: busy wins, no mode change.
- Reset asserted mid-press: outputs clear immediately. The press is discarded by the arming rule.
- `mode` wrap: 11 → 00, with no skipped states.
- `stop` follows `setting_busy` by exactly 1 cycle, independent of `tick`.

## Test plan

1. **Reset mid-press.** Reset with b0 held. Release reset, keep b0 held for 150 ticks, then release.
   → No events; `mode` stays 00.
2. **Short press.** b0 pressed for 3 ticks, then released.
   → `b0short` high for one tick period starting 1 clk after the release tick; `mode` 00 → 01 in that same cycle.
3. **Long press.** b1 held for 120 ticks.
   → `b1long` rises 1 clk after the 100th pressed tick. No further events, and no `b1short` on release.
4. **Mode wrap.** Four b0 short presses with `setting_busy`=0.
   → `mode` sequence 01, 10, 11, 00.
5. **Busy blocks mode change.** `setting_busy`=1, then a b0 short press.
   → `mode` unchanged and `b0short` still asserted. `stop` rises 1 clk after `setting_busy` rises and falls 1 clk after it falls.
6. **Simultaneous buttons.** b0 and b1 both pressed for 5 ticks, released on the same tick.
   → `b0short` and `b1short` rise in the same cycle; `mode` advances by exactly one.
